// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with registered status flags, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow errors and a standard or first-word-fall-through read port.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2,
    parameter bit          FWFT          = 1'b0
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_enable,
    output logic                       wr_busy_flag,
    input  logic                       rd_enable,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       rd_busy_flag,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clear
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  wr_busy_q, rd_busy_q, afull_q, aempty_q;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_acc, rd_acc;

    // Acceptance uses the registered start-of-cycle full/empty flags.
    assign wr_acc = wr_enable & ~wr_busy_q;
    assign rd_acc = rd_enable & ~rd_busy_q;

    always_comb begin
        level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
        ovf_d   = err_clear ? 1'b0 : ovf_q;
        unf_d   = err_clear ? 1'b0 : unf_q;
        if (wr_enable && wr_busy_q) begin
            ovf_d = 1'b1;
        end
        if (rd_enable && rd_busy_q) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            wr_busy_q <= 1'b0;
            rd_busy_q <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_acc) begin
                rptr_q <= rptr_q + AW'(1);
            end
            level_q   <= level_d;
            wr_busy_q <= (level_d == LW'(DEPTH));
            rd_busy_q <= (level_d == '0);
            afull_q   <= (level_d >= LW'(AFULL_THRESH));
            aempty_q  <= (level_d <= LW'(AEMPTY_THRESH));
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (res_n && wr_acc) begin
            mem[wptr_q] <= wr_data;
        end
    end

    if (FWFT) begin : g_fwft
        assign rd_data  = rd_busy_q ? '0 : mem[rptr_q];
        assign rd_valid = ~rd_busy_q;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk) begin
            if (!res_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem[rptr_q];
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

    assign wr_busy_flag = wr_busy_q;
    assign rd_busy_flag = rd_busy_q;
    assign level        = level_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
